// File: rtl/risc8_dma_if.sv
// risc8_dma_if
//   Bundles the three buses that meet at the DMA engine.
//   - IO register bus: addr, ren, wen, wdata in; rdata, valid out.
//   - Core data bus: cpu_addr, cpu_ren, cpu_wen, cpu_wdata.
//   - Data RAM port: mem_addr, mem_wen, mem_wdata out; mem_rdata back.
//   Modports:
//   - slave: the DMA engine's view.
//   - master: the surrounding system's view (core, IO decode, RAM).
interface risc8_dma_if;
  logic [6:0]  addr;
  logic        ren;
  logic        wen;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        valid;
  logic [15:0] cpu_addr;
  logic        cpu_ren;
  logic        cpu_wen;
  logic [7:0]  cpu_wdata;
  logic [15:0] mem_addr;
  logic        mem_wen;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport slave (
    input  addr, ren, wen, wdata, cpu_addr, cpu_ren, cpu_wen, cpu_wdata, mem_rdata,
    output rdata, valid, mem_addr, mem_wen, mem_wdata
  );

  modport master (
    output addr, ren, wen, wdata, cpu_addr, cpu_ren, cpu_wen, cpu_wdata, mem_rdata,
    input  rdata, valid, mem_addr, mem_wen, mem_wdata
  );
endinterface

// File: rtl/risc8_dma.sv
// risc8_dma
//   Memory-to-memory byte copy engine for the risc8.
//   It shares the single-port data RAM with the core by cycle stealing.
//   The core always owns the RAM in any cycle where it asserts cpu_ren or cpu_wen.
//   The engine only uses cycles the core leaves idle.
//   Programmed through six IO registers starting at BASE:
//     +0 SRC_L  +1 SRC_H  +2 DST_L  +3 DST_H  +4 LEN (0 = 256)
//     +5 CTRL   write: b0 START, b1 CLRDONE, b2 ABORT, b3 IE
//               read : {4'b0, IE, 1'b0, DONE, BUSY}
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    risc8_dma_if.slave: IO register bus, core data bus and RAM port
//   irq    high while DONE and IE are both set
module risc8_dma #(
  parameter logic [6:0] BASE = 7'h30
) (
  input  logic       clk,
  input  logic       reset,
  risc8_dma_if.slave bus,
  output logic       irq
);

  // One byte moves as three steps:
  //   RD  presents SRC to the RAM.
  //   CAP catches the registered read data.
  //   WR  writes the byte to DST.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    WR   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] srcAddr_q;
  logic [15:0] dstAddr_q;
  logic [7:0]  len_q;
  logic [7:0]  data_q;
  logic        ie_q;
  logic        done_q;
  logic [7:0]  rdata_q;
  logic        valid_q;

  logic [6:0]  offset;
  logic        ioHit;
  logic        cpuBusy;
  logic        busy;
  logic        regWrite;
  logic        ctrlWrite;
  logic        abortReq;
  logic        startReq;
  logic        clrDoneReq;
  logic        dmaDrive;
  logic        dmaWen;
  logic [15:0] dmaAddr;
  logic        wrFire;
  logic        lastByte;
  logic [7:0]  readMux;

  // Register decode.
  // Subtracting BASE makes any address below the window wrap to a large offset.
  // A single "< 6" compare therefore covers both ends of the window.
  assign offset     = bus.addr - BASE;
  assign ioHit      = (offset < 7'd6);
  assign cpuBusy    = bus.cpu_ren | bus.cpu_wen;
  assign busy       = (state_q != IDLE);
  assign ctrlWrite  = bus.wen & ioHit & (offset == 7'd5);
  assign regWrite   = bus.wen & ioHit & (offset != 7'd5) & ~busy;
  assign abortReq   = ctrlWrite & bus.wdata[2];
  assign clrDoneReq = ctrlWrite & bus.wdata[1];
  assign startReq   = ctrlWrite & bus.wdata[0] & ~busy & ~abortReq;

  // LEN itself serves as the remaining-byte counter.
  // A programmed 0 decrements through 255 down to 1.
  // That gives 256 bytes with no separate 9-bit counter.
  assign lastByte = wrFire & (len_q == 8'd1);

  // Next-state and DMA bus request.
  // ABORT, and reset in the same cycle, cancel any access the engine would make.
  // So an abort landing on WR never reaches the RAM.
  always_comb begin
    state_d  = state_q;
    dmaDrive = 1'b0;
    dmaWen   = 1'b0;
    dmaAddr  = 16'h0000;
    wrFire   = 1'b0;

    case (state_q)
      IDLE: begin
        if (startReq) begin
          state_d = RD;
        end
      end
      RD: begin
        if (!cpuBusy) begin
          dmaDrive = 1'b1;
          dmaAddr  = srcAddr_q;
          state_d  = CAP;
        end
      end
      CAP: begin
        state_d = WR;
      end
      WR: begin
        if (!cpuBusy) begin
          dmaDrive = 1'b1;
          dmaWen   = 1'b1;
          dmaAddr  = dstAddr_q;
          wrFire   = 1'b1;
          state_d  = (len_q == 8'd1) ? IDLE : RD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abortReq || reset) begin
      state_d  = IDLE;
      dmaDrive = 1'b0;
      dmaWen   = 1'b0;
      wrFire   = 1'b0;
    end
  end

  // RAM port mux.
  // The core wins whenever it requests the RAM.
  // With nobody using the RAM, the core address is passed through and the write enable stays low.
  always_comb begin
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wen   = bus.cpu_wen;
    bus.mem_wdata = bus.cpu_wdata;
    if (!cpuBusy && dmaDrive) begin
      bus.mem_addr  = dmaAddr;
      bus.mem_wen   = dmaWen;
      bus.mem_wdata = data_q;
    end
  end

  // IO read data source.
  // Live values are returned.
  // Software can watch SRC, DST and LEN move during a transfer.
  always_comb begin
    readMux = 8'h00;
    case (offset)
      7'd0:    readMux = srcAddr_q[7:0];
      7'd1:    readMux = srcAddr_q[15:8];
      7'd2:    readMux = dstAddr_q[7:0];
      7'd3:    readMux = dstAddr_q[15:8];
      7'd4:    readMux = len_q;
      7'd5:    readMux = {4'b0000, ie_q, 1'b0, done_q, busy};
      default: readMux = 8'h00;
    endcase
  end

  // State and register updates.
  // Register writes only happen while idle.
  // Address/count advances only happen while busy.
  // So the two branches never compete for the same flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      srcAddr_q <= 16'h0000;
      dstAddr_q <= 16'h0000;
      len_q     <= 8'h00;
      data_q    <= 8'h00;
      ie_q      <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= 8'h00;
      valid_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (regWrite) begin
        case (offset)
          7'd0:    srcAddr_q[7:0]  <= bus.wdata;
          7'd1:    srcAddr_q[15:8] <= bus.wdata;
          7'd2:    dstAddr_q[7:0]  <= bus.wdata;
          7'd3:    dstAddr_q[15:8] <= bus.wdata;
          7'd4:    len_q           <= bus.wdata;
          default: ;
        endcase
      end else if (wrFire) begin
        srcAddr_q <= srcAddr_q + 16'd1;
        dstAddr_q <= dstAddr_q + 16'd1;
        len_q     <= len_q - 8'd1;
      end

      if (ctrlWrite) begin
        ie_q <= bus.wdata[3];
      end

      if (lastByte) begin
        done_q <= 1'b1;
      end else if (clrDoneReq) begin
        done_q <= 1'b0;
      end

      // RAM read data is registered.
      // In CAP it reflects the SRC address presented during RD.
      // This holds even if the core grabs the RAM in CAP.
      if (state_q == CAP) begin
        data_q <= bus.mem_rdata;
      end

      valid_q <= bus.ren & ioHit;
      rdata_q <= (bus.ren & ioHit) ? readMux : 8'h00;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.valid = valid_q;
  assign irq       = done_q & ie_q;

endmodule
